// File: rtl/seq_div_unit.sv
// Multi-cycle unsigned restoring divider with valid/ready handshakes on both sides.
// Resolves one quotient bit per clock, MSB first; a zero divisor short-circuits to a flagged result.
module seq_div_unit #(
  parameter int unsigned DIVIDEND_W = 5,
  parameter int unsigned DIVISOR_W  = 3,
  parameter int unsigned FIT_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  quot_fits,
  output logic                  div_by_zero
);

  localparam int unsigned PW    = DIVISOR_W + 1;
  localparam int unsigned CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [PW-1:0]         prem_q, prem_d;
  logic [DIVIDEND_W-1:0] wq_q, wq_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic                  fits_q, fits_d;
  logic                  dbz_q, dbz_d;

  logic                  accept, last, ge;
  logic [PW-1:0]         rem_shift, rem_next;
  logic [DIVIDEND_W-1:0] quo_next;

  assign accept = in_valid && in_ready;
  assign last   = (cnt_q == CNT_W'(DIVIDEND_W - 1));

  // One restoring step: bring in the next dividend bit, subtract if the divisor fits.
  assign rem_shift = (prem_q << 1) | PW'(dvd_q[DIVIDEND_W-1]);
  assign ge        = (rem_shift >= {1'b0, dvs_q});
  assign rem_next  = ge ? (rem_shift - {1'b0, dvs_q}) : rem_shift;
  assign quo_next  = (wq_q << 1) | DIVIDEND_W'(ge);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = (divisor == '0) ? DONE : CALC;
      CALC: if (last) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_comb begin
    cnt_d  = cnt_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    prem_d = prem_q;
    wq_d   = wq_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    fits_d = fits_q;
    dbz_d  = dbz_q;
    if (state_q == IDLE && accept) begin
      dvd_d  = dividend;
      dvs_d  = divisor;
      cnt_d  = '0;
      prem_d = '0;
      wq_d   = '0;
      if (divisor == '0) begin
        quo_d  = '1;
        rem_d  = '0;
        fits_d = 1'b0;
        dbz_d  = 1'b1;
      end
    end else if (state_q == CALC) begin
      dvd_d  = dvd_q << 1;
      prem_d = rem_next;
      wq_d   = quo_next;
      cnt_d  = cnt_q + CNT_W'(1);
      if (last) begin
        quo_d  = quo_next;
        rem_d  = DIVISOR_W'(rem_next);
        fits_d = ((quo_next >> FIT_W) == '0);
        dbz_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      prem_q <= '0;
      wq_q   <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      fits_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      prem_q <= prem_d;
      wq_q   <= wq_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      fits_q <= fits_d;
      dbz_q  <= dbz_d;
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign quot_fits   = fits_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div_unit.sv
// Self-checking bench for seq_div_unit: directed vector table, handshake corner cases,
// and randomized operands checked against plain integer division.
module tb_seq_div_unit;

  localparam int unsigned DW = 5;
  localparam int unsigned SW = 3;
  localparam int unsigned FW = 2;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [SW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [SW-1:0] remainder;
  logic          quot_fits;
  logic          div_by_zero;

  int vec_cnt = 0;
  int err_cnt = 0;

  seq_div_unit #(.DIVIDEND_W(DW), .DIVISOR_W(SW), .FIT_W(FW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .quot_fits  (quot_fits),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned a;
    int unsigned b;
    int unsigned q;
    int unsigned r;
    int unsigned fits;
    int unsigned dbz;
    int unsigned stall;
  } vec_t;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_quotient"}, quotient, 0);
    chk({tag, "_remainder"}, remainder, 0);
    chk({tag, "_quot_fits"}, quot_fits, 0);
    chk({tag, "_div_by_zero"}, div_by_zero, 0);
  endtask

  // Drive one transaction from the point just after a clock edge with the DUT idle.
  // Operands and in_valid are scrambled while busy; none of that may be accepted.
  task automatic do_op(input int unsigned a, input int unsigned b, input int unsigned q,
                       input int unsigned r, input int unsigned fits, input int unsigned dbz,
                       input int unsigned stall, input string tag);
    int unsigned lat;
    int unsigned exp_lat;
    logic [DW-1:0] held_q;
    logic [SW-1:0] held_r;
    logic held_f, held_z;
    // Zero divisor: result visible right after the accepting edge; otherwise one edge per bit.
    exp_lat = (b == 0) ? 0 : DW;
    chk({tag, "_ready_before"}, in_ready, 1);
    in_valid  = 1'b1;
    dividend  = DW'(a);
    divisor   = SW'(b);
    out_ready = 1'b0;
    @(posedge clk); #1;
    lat = 0;
    while (!out_valid && lat < 40) begin
      chk({tag, "_busy_ready"}, in_ready, 0);
      in_valid = 1'($urandom);
      dividend = DW'($urandom);
      divisor  = SW'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_out_valid"}, out_valid, 1);
    chk({tag, "_quotient"}, quotient, q);
    chk({tag, "_remainder"}, remainder, r);
    chk({tag, "_quot_fits"}, quot_fits, fits);
    chk({tag, "_div_by_zero"}, div_by_zero, dbz);
    held_q = quotient;
    held_r = remainder;
    held_f = quot_fits;
    held_z = div_by_zero;
    for (int i = 0; i < int'(stall); i++) begin
      in_valid = 1'($urandom);
      dividend = DW'($urandom);
      divisor  = SW'($urandom);
      @(posedge clk); #1;
      chk({tag, "_stall_valid"}, out_valid, 1);
      chk({tag, "_stall_ready"}, in_ready, 0);
      chk({tag, "_stall_q"}, quotient, q);
      chk({tag, "_stall_hold"}, {held_q, held_r, held_f, held_z},
          {quotient, remainder, quot_fits, div_by_zero});
    end
    // Offer an operand on the draining edge; it must not be taken.
    in_valid  = 1'b1;
    dividend  = DW'($urandom);
    divisor   = SW'($urandom);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk({tag, "_drain_valid"}, out_valid, 0);
    chk({tag, "_drain_idle"}, in_ready, 1);
    chk({tag, "_idle_keep_q"}, quotient, q);
  endtask

  vec_t tbl[$];

  initial begin
    int unsigned a, b, q, r, f, z;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #1;
    chk_reset_outputs("reset_start");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    tbl.push_back('{a: 21, b: 7, q: 3,  r: 0, fits: 1, dbz: 0, stall: 0});
    tbl.push_back('{a: 23, b: 3, q: 7,  r: 2, fits: 0, dbz: 0, stall: 0});
    tbl.push_back('{a: 31, b: 1, q: 31, r: 0, fits: 0, dbz: 0, stall: 0});
    tbl.push_back('{a: 0,  b: 5, q: 0,  r: 0, fits: 1, dbz: 0, stall: 0});
    tbl.push_back('{a: 5,  b: 0, q: 31, r: 0, fits: 0, dbz: 1, stall: 0});
    tbl.push_back('{a: 30, b: 4, q: 7,  r: 2, fits: 0, dbz: 0, stall: 1});
    tbl.push_back('{a: 4,  b: 7, q: 0,  r: 4, fits: 1, dbz: 0, stall: 0});
    tbl.push_back('{a: 15, b: 4, q: 3,  r: 3, fits: 1, dbz: 0, stall: 2});
    tbl.push_back('{a: 31, b: 7, q: 4,  r: 3, fits: 0, dbz: 0, stall: 0});
    tbl.push_back('{a: 21, b: 7, q: 3,  r: 0, fits: 1, dbz: 0, stall: 10});
    foreach (tbl[i])
      do_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].fits, tbl[i].dbz,
            tbl[i].stall, $sformatf("tbl%0d", i));

    for (int n = 0; n < 60; n++) begin
      a = $urandom_range(0, 31);
      b = $urandom_range(0, 7);
      if (b == 0) begin
        q = 31; r = 0; f = 0; z = 1;
      end else begin
        q = a / b; r = a % b; f = (q < (1 << FW)) ? 1 : 0; z = 0;
      end
      do_op(a, b, q, r, f, z, $urandom_range(0, 3), $sformatf("rnd%0d", n));
    end

    // Leave a distinctive result on the outputs, then abort the next division mid-flight.
    do_op(5, 0, 31, 0, 0, 1, 0, "pre_abort");
    in_valid = 1'b1;
    dividend = DW'(13);
    divisor  = SW'(3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort_async");
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("abort_held");
    rst_n = 1'b1;
    do_op(6, 2, 3, 0, 1, 0, 0, "after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", err_cnt);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_div_unit.md
SEQ_DIV_UNIT -- requirements
Module: seq_div_unit

Interface
REQ-001 SHALL have parameter DIVIDEND_W, default 5, dividend and quotient width (matches 2x3 product width).
REQ-002 SHALL have parameter DIVISOR_W, default 3, divisor and remainder width.
REQ-003 SHALL have parameter FIT_W, default 2, width the quotient is checked against for the fits flag.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1, operand pair offered.
REQ-007 SHALL have port in_ready, output, 1, block accepts operands.
REQ-008 SHALL have port dividend, input, DIVIDEND_W, unsigned numerator.
REQ-009 SHALL have port divisor, input, DIVISOR_W, unsigned denominator.
REQ-010 SHALL have port out_valid, output, 1, result held valid.
REQ-011 SHALL have port out_ready, input, 1, consumer takes result.
REQ-012 SHALL have port quotient, output, DIVIDEND_W, unsigned floor(dividend/divisor).
REQ-013 SHALL have port remainder, output, DIVISOR_W, dividend mod divisor.
REQ-014 SHALL have port quot_fits, output, 1, quotient < 2^FIT_W.
REQ-015 SHALL have port div_by_zero, output, 1, divisor was zero.

Function
REQ-016 SHALL implement FSM states IDLE, CALC, DONE.
REQ-017 SHALL drive in_ready high only in IDLE; out_valid high only in DONE.
REQ-018 SHALL accept operands on a rising edge with in_valid and in_ready both high, latching dividend and divisor internally.
REQ-019 SHALL, on acceptance with divisor nonzero, enter CALC with iteration counter 0 and partial remainder 0 (DIVISOR_W+1 bits wide).
REQ-020 SHALL, in CALC, resolve one quotient bit per cycle MSB first by restoring division: shift next dividend bit into partial remainder; if partial remainder >= divisor, subtract and set the quotient bit, else clear it.
REQ-021 SHALL, after exactly DIVIDEND_W CALC cycles, enter DONE with quotient, remainder, quot_fits registered; out_valid thus rises DIVIDEND_W cycles after the accepting edge.
REQ-022 SHALL, on acceptance with divisor zero, go directly to DONE (out_valid one cycle after the accepting edge) with quotient all ones, remainder 0, quot_fits 0, div_by_zero 1.
REQ-023 SHALL clear div_by_zero for every nonzero-divisor result.
REQ-024 SHALL hold all result outputs stable in DONE until out_ready is sampled high; out_ready low stalls indefinitely.
REQ-025 SHALL return to IDLE on the edge where out_valid and out_ready are both high; no new operand is accepted on that same edge.
REQ-026 SHALL ignore in_valid and operand changes while in CALC or DONE.
REQ-027 SHALL keep result outputs at their last value in IDLE and CALC; only out_valid qualifies them.
REQ-028 SHALL guarantee remainder < divisor and quotient*divisor + remainder = dividend for every nonzero divisor.

Reset
REQ-029 SHALL, while rst_n is low, force state IDLE, in_ready 1, out_valid 0, quotient 0, remainder 0, quot_fits 0, div_by_zero 0, counter and partial remainder 0.
REQ-030 SHALL abort any operation in CALC or DONE on reset assertion, discarding it; first acceptance possible on the first rising edge after rst_n deasserts.

Verification
REQ-031 SHALL verify dividend 21, divisor 7 -> out_valid 5 cycles after accept, quotient 3, remainder 0, quot_fits 1, div_by_zero 0.
REQ-032 SHALL verify dividend 23, divisor 3 -> quotient 7, remainder 2, quot_fits 0.
REQ-033 SHALL verify dividend 31, divisor 1 -> quotient 31, remainder 0; and dividend 0, divisor 5 -> quotient 0, remainder 0, quot_fits 1.
REQ-034 SHALL verify dividend 5, divisor 0 -> out_valid one cycle after accept, quotient 31, remainder 0, div_by_zero 1.
REQ-035 SHALL verify out_ready held low 10 cycles in DONE -> outputs and out_valid stable, in_ready 0; in_valid pulsed during CALC -> not accepted.
REQ-036 SHALL verify rst_n asserted in CALC cycle 3 -> outputs at reset values immediately; next request 6/2 -> quotient 3, remainder 0.
